// File: rtl/descriptor_fetch_master_if.sv
// Descriptor fetch bus bundle: Avalon-MM master port to the descriptor
// memory plus the descriptor valid/ready handoff to the DMA datapath.
interface descriptor_fetch_master_if #(
  parameter int ADDR_W     = 32,
  parameter int DESC_WORDS = 8
);
  // descriptor handoff
  logic                         desc_valid;
  logic                         desc_ready;
  logic [DESC_WORDS-1:0][31:0]  desc_data;
  logic [ADDR_W-1:0]            desc_addr;
  // Avalon-MM
  logic [ADDR_W-1:0]            m_address;
  logic                         m_read;
  logic                         m_write;
  logic [31:0]                  m_writedata;
  logic [3:0]                   m_byteenable;
  logic                         m_waitrequest;
  logic [31:0]                  m_readdata;
  logic                         m_readdatavalid;

  modport master (
    output desc_valid, desc_data, desc_addr,
    input  desc_ready,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  desc_valid, desc_data, desc_addr,
    output desc_ready,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/descriptor_fetch_master.sv
// Scatter-gather descriptor walker. Fetches one descriptor with pipelined
// single-word reads, drops the chain when the ownership bit is clear,
// hands owned descriptors to the datapath, writes the status word back and
// follows the next pointer.
module descriptor_fetch_master #(
  parameter int ADDR_W      = 32,
  parameter int DESC_WORDS  = 8,
  parameter int NEXT_WORD   = 4,
  parameter int STATUS_WORD = 7,
  parameter int OWN_BIT     = 31,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              chain_end,
  input  logic              wb_req,
  input  logic [31:0]       wb_data,
  input  logic [3:0]        wb_byteenable,
  descriptor_fetch_master_if.master bus
);
  localparam int CW = $clog2(DESC_WORDS + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0]     NUM_WORDS  = CW'(DESC_WORDS);
  localparam logic [CW-1:0]     LAST_IDX   = CW'(DESC_WORDS - 1);
  localparam logic [PW-1:0]     PEND_LIMIT = PW'(MAX_PENDING);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] STATUS_OFS = ADDR_W'(4 * STATUS_WORD);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, PRESENT, WAIT_WB, WRITE} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0]           cur_addr;
  logic [ADDR_W-1:0]           next_ptr;
  logic [CW-1:0]               issued;
  logic [CW-1:0]               recv;
  logic [PW-1:0]               pending;
  logic [DESC_WORDS-1:0][31:0] words;
  logic                        stop_q;
  logic                        rd_issue, wr_issue;
  logic                        rd_accept, wr_done, rsp, owned;

  assign owned          = words[STATUS_WORD][OWN_BIT];
  assign next_ptr       = ADDR_W'(words[NEXT_WORD]) & ALIGN_MASK;
  // Responses only count while fetching; stragglers after a reset are dropped.
  assign rsp            = (state == FETCH) && bus.m_readdatavalid;
  assign rd_accept      = rd_issue && !bus.m_waitrequest;
  assign wr_done        = wr_issue && !bus.m_waitrequest;
  // Reset kills bus commands in the same cycle, not one cycle later.
  assign bus.m_read     = rd_issue && !reset;
  assign bus.m_write    = wr_issue && !reset;
  assign bus.desc_data  = words;
  assign busy           = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and bus command decode
  always_comb begin
    state_d  = state;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    case (state)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
        rd_issue = (issued < NUM_WORDS) && (pending < PEND_LIMIT);
        if (rsp && recv == LAST_IDX) state_d = CHECK;
      end
      CHECK:   state_d = owned ? PRESENT : IDLE;
      PRESENT: if (bus.desc_valid && bus.desc_ready) state_d = WAIT_WB;
      WAIT_WB: if (wb_req) state_d = WRITE;
      WRITE: begin
        wr_issue = 1'b1;
        if (!bus.m_waitrequest) state_d = stop_q ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/counter datapath, descriptor capture and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr         <= '0;
      issued           <= '0;
      recv             <= '0;
      pending          <= '0;
      words            <= '0;
      stop_q           <= 1'b0;
      done             <= 1'b0;
      chain_end        <= 1'b0;
      bus.desc_valid   <= 1'b0;
      bus.desc_addr    <= '0;
      bus.m_address    <= '0;
      bus.m_writedata  <= '0;
      bus.m_byteenable <= 4'hF;
    end else begin
      done <= 1'b0;
      if (state != IDLE && stop) stop_q <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cur_addr      <= start_addr & ALIGN_MASK;
          bus.m_address <= start_addr & ALIGN_MASK;
          issued        <= '0;
          recv          <= '0;
          pending       <= '0;
          chain_end     <= 1'b0;
          stop_q        <= 1'b0;
        end
        FETCH: begin
          if (rd_accept) begin
            bus.m_address <= bus.m_address + WORD_STEP;
            issued        <= issued + 1'b1;
          end
          if (rsp) begin
            for (int i = 0; i < DESC_WORDS; i++)
              if (recv == CW'(i)) words[i] <= bus.m_readdata;
            recv <= recv + 1'b1;
          end
          case ({rd_accept, rsp})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: ;
          endcase
        end
        CHECK: begin
          if (owned) begin
            bus.desc_valid <= 1'b1;
            bus.desc_addr  <= cur_addr;
          end else begin
            chain_end <= 1'b1;
            done      <= 1'b1;
          end
        end
        PRESENT: if (bus.desc_ready) bus.desc_valid <= 1'b0;
        WAIT_WB: if (wb_req) begin
          bus.m_writedata  <= wb_data;
          bus.m_byteenable <= wb_byteenable;
          bus.m_address    <= cur_addr + STATUS_OFS;
        end
        WRITE: if (wr_done) begin
          bus.m_byteenable <= 4'hF;
          issued           <= '0;
          recv             <= '0;
          pending          <= '0;
          if (stop_q) begin
            done      <= 1'b1;
            chain_end <= 1'b0;
          end else begin
            cur_addr      <= next_ptr;
            bus.m_address <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
